// File: rtl/demux_width_chan_pack.sv
// rtl/demux_width_chan_pack.sv - packs WIDTH-bit words into CHANNELS slots, hands the full bus off with valid/ready
// Optional DEMUX_WIDTH_CHAN_AUTOINC_EN: slot comes from an internal pointer instead of sel.
module demux_width_chan_pack #(
    parameter int WIDTH      = 3,
    parameter int CHANNELS   = 8,
    parameter int SEL_LENGTH = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [WIDTH-1:0]          in,
    input  logic [SEL_LENGTH-1:0]     sel,
    input  logic                      wr_en,
    input  logic                      clear,
    input  logic                      out_ready,
    output logic [WIDTH*CHANNELS-1:0] out_bus,
    output logic                      out_valid,
    output logic [CHANNELS-1:0]       fill_mask,
    output logic                      err
);

    localparam logic [0:0] FILL = 1'b0;
    localparam logic [0:0] HOLD = 1'b1;

    logic [0:0]            state;
    logic [SEL_LENGTH-1:0] slot;
    logic [CHANNELS-1:0]   hit;

`ifdef DEMUX_WIDTH_CHAN_AUTOINC_EN
    logic [SEL_LENGTH-1:0] ptr;
    logic                  unused_sel;
    assign slot       = ptr;
    assign unused_sel = ^sel;
`else
    assign slot = sel;
`endif

    // One-hot slot decode; an out-of-range index leaves hit all zero.
    always_comb begin
        hit = '0;
        for (int k = 0; k < CHANNELS; k++) begin
            if (slot == SEL_LENGTH'(k)) hit[k] = 1'b1;
        end
    end

    assign out_valid = (state == HOLD);

    always_ff @(posedge clk) begin
        if (rst) begin
            out_bus   <= '0;
            fill_mask <= '0;
            state     <= FILL;
            err       <= 1'b0;
`ifdef DEMUX_WIDTH_CHAN_AUTOINC_EN
            ptr       <= '0;
`endif
        end else begin
            err <= 1'b0;
            if (clear) begin
                fill_mask <= '0;
                state     <= FILL;
`ifdef DEMUX_WIDTH_CHAN_AUTOINC_EN
                ptr       <= '0;
`endif
            end else if (state == HOLD) begin
                err <= wr_en;
                if (out_ready) begin
                    fill_mask <= '0;
                    state     <= FILL;
`ifdef DEMUX_WIDTH_CHAN_AUTOINC_EN
                    ptr       <= '0;
`endif
                end
            end else if (wr_en) begin
                if (|hit) begin
                    for (int k = 0; k < CHANNELS; k++) begin
                        if (hit[k]) out_bus[k*WIDTH +: WIDTH] <= in;
                    end
                    fill_mask <= fill_mask | hit;
                    // Data and valid land on the same edge as the last write.
                    if ((fill_mask | hit) == {CHANNELS{1'b1}}) state <= HOLD;
`ifdef DEMUX_WIDTH_CHAN_AUTOINC_EN
                    ptr <= ptr + SEL_LENGTH'(1);
`endif
                end else begin
                    err <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_demux_width_chan_pack.sv
// tb/tb_demux_width_chan_pack.sv - self-checking bench for demux_width_chan_pack
module tb_demux_width_chan_pack;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [2:0]  in_w = '0;
    logic [3:0]  sel = '0;
    logic        wr_en = 1'b0;
    logic        clear = 1'b0;
    logic        out_ready = 1'b0;
    logic [23:0] out_bus;
    logic        out_valid;
    logic [7:0]  fill_mask;
    logic        err;

    int checks = 0;
    int errors = 0;

    logic [2:0] m_bus [8];
    bit         m_fill [8];
    bit         m_valid;
    bit         m_err;

    demux_width_chan_pack #(.WIDTH(3), .CHANNELS(8), .SEL_LENGTH(4)) dut (
        .clk(clk), .rst(rst), .in(in_w), .sel(sel), .wr_en(wr_en),
        .clear(clear), .out_ready(out_ready), .out_bus(out_bus),
        .out_valid(out_valid), .fill_mask(fill_mask), .err(err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic int filled_count();
        int n = 0;
        for (int k = 0; k < 8; k++) n += int'(m_fill[k]);
        return n;
    endfunction

    task automatic drop_fill();
        for (int k = 0; k < 8; k++) m_fill[k] = 0;
        m_valid = 0;
    endtask

    task automatic step(input logic we, input logic [3:0] s, input logic [2:0] d,
                        input logic clr, input logic rdy, input logic rs);
        int          idx;
        logic [23:0] e_bus;
        logic [7:0]  e_mask;
        wr_en = we; sel = s; in_w = d; clear = clr; out_ready = rdy; rst = rs;
        @(posedge clk);
        #1;
        if (rs) begin
            for (int k = 0; k < 8; k++) m_bus[k] = '0;
            drop_fill();
            m_err = 0;
        end else begin
            m_err = 0;
            if (clr) begin
                drop_fill();
            end else if (m_valid) begin
                if (we) m_err = 1;
                if (rdy) drop_fill();
            end else if (we) begin
`ifdef DEMUX_WIDTH_CHAN_AUTOINC_EN
                idx = filled_count();
`else
                idx = int'(s);
`endif
                if (idx < 8) begin
                    m_bus[idx]  = d;
                    m_fill[idx] = 1;
                    if (filled_count() == 8) m_valid = 1;
                end else begin
                    m_err = 1;
                end
            end
        end
        for (int k = 0; k < 8; k++) begin
            e_bus[k*3 +: 3] = m_bus[k];
            e_mask[k]       = m_fill[k];
        end
        chk("out_bus", 32'(out_bus), 32'(e_bus));
        chk("fill_mask", 32'(fill_mask), 32'(e_mask));
        chk("out_valid", 32'(out_valid), 32'(m_valid));
        chk("err", 32'(err), 32'(m_err));
    endtask

    initial begin
        for (int k = 0; k < 8; k++) begin m_bus[k] = '0; m_fill[k] = 0; end
        m_valid = 0; m_err = 0;

        // reset with a write strobe pending
        step(1, 4'd3, 3'd7, 0, 0, 1);
        chk("reset_bus", 32'(out_bus), 32'h0);

        // single write
        step(1, 4'd2, 3'b101, 0, 0, 0);
`ifndef DEMUX_WIDTH_CHAN_AUTOINC_EN
        chk("t2_slot", 32'(out_bus[8:6]), 32'b101);
        chk("t2_mask", 32'(fill_mask), 32'h04);
`endif

        // full fill, hold, handshake
        for (int k = 0; k < 8; k++) step(1, 4'(k), 3'(k), 0, 0, 0);
        chk("t3_valid", 32'(out_valid), 32'h1);
        chk("t3_bus", 32'(out_bus), 32'(24'o76543210));
        for (int i = 0; i < 3; i++) step(0, 4'd0, 3'd0, 0, 0, 0);
        step(0, 4'd0, 3'd0, 0, 1, 0);
        chk("t3_after_hs", 32'(out_bus), 32'(24'o76543210));
        chk("t3_valid_low", 32'(out_valid), 32'h0);

        // out-of-range write, then err must drop again
        step(1, 4'd9, 3'd5, 0, 0, 0);
        step(0, 4'd0, 3'd0, 0, 0, 0);
        // writes during HOLD, including the handshake cycle
        for (int k = 0; k < 8; k++) step(1, 4'(7 - k), 3'($urandom), 0, 0, 0);
        step(1, 4'd1, 3'd6, 0, 0, 0);
        step(1, 4'd2, 3'd1, 0, 1, 0);
        step(0, 4'd0, 3'd0, 0, 0, 0);

        // clear with a same-cycle write after 5 slots; clear beats handshake
        for (int k = 0; k < 5; k++) step(1, 4'(k), 3'($urandom), 0, 0, 0);
        step(1, 4'd5, 3'd3, 1, 0, 0);
        chk("t5_clear_mask", 32'(fill_mask), 32'h0);
        for (int k = 0; k < 8; k++) step(1, 4'(k), 3'($urandom), 0, 0, 0);
        step(0, 4'd0, 3'd0, 1, 1, 0);
        // reset after 3 slots
        for (int k = 0; k < 3; k++) step(1, 4'(k), 3'($urandom), 0, 0, 0);
        step(0, 4'd0, 3'd0, 0, 0, 1);
        chk("t5_rst_bus", 32'(out_bus), 32'h0);

        // randomized traffic
        for (int i = 0; i < 400; i++) begin
            step(logic'($urandom_range(0, 3) != 0), 4'($urandom_range(0, 11)), 3'($urandom),
                 logic'($urandom_range(0, 19) == 0), logic'($urandom_range(0, 1)),
                 logic'($urandom_range(0, 63) == 0));
        end

`ifdef DEMUX_WIDTH_CHAN_AUTOINC_EN
        step(0, 4'd0, 3'd0, 1, 0, 0);
        for (int k = 0; k < 8; k++) step(1, 4'($urandom), 3'(7 - k), 0, 0, 0);
        chk("t6_bus", 32'(out_bus), 32'(24'o01234567));
        chk("t6_valid", 32'(out_valid), 32'h1);
        for (int k = 0; k < 8; k++) chk("t6_mux", 32'(out_bus[k*3 +: 3]), 32'(7 - k));
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
